// File: rtl/key_debounce_pkg.sv
// Shared types for the key debounce array.
// Holds the per-channel auto-repeat state and a width helper.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        HOLD     = 2'd1,
        REPEAT   = 2'd2
    } rep_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounced key channel: synchronizer, stability counter
// and auto-repeat state machine with registered pulses.
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int DEB_CYCLES    = 250000,
    parameter int ACTIVE_LOW    = 1,
    parameter int REPEAT_DELAY  = 12500000,
    parameter int REPEAT_PERIOD = 2500000
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    input  logic repeat_en,
    output logic level,
    output logic neg,
    output logic pos,
    output logic neg_next
);

    localparam logic IDLE_LVL = (ACTIVE_LOW != 0);
    localparam int   CW = $clog2(DEB_CYCLES);
    localparam int   TW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    logic          sync1;
    logic          sync2;
    logic          sample;
    logic          accept;
    logic          repeat_hit;
    logic [CW-1:0] cnt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_end;
    rep_state_e    state;

    // sample is 1 when the key is pressed, whatever the pin polarity
    assign sample = sync2 ^ IDLE_LVL;
    assign accept = (sample != level) && (cnt == CW'(DEB_CYCLES - 1));

    always_comb begin
        timer_end  = (state == REPEAT) ? TW'(REPEAT_PERIOD - 1)
                                       : TW'(REPEAT_DELAY - 1);
        repeat_hit = (state != RELEASED) && repeat_en &&
                     (timer == timer_end) && !accept;
        neg_next   = (accept && sample) || repeat_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= IDLE_LVL;
            sync2 <= IDLE_LVL;
            cnt   <= '0;
            level <= 1'b0;
            neg   <= 1'b0;
            pos   <= 1'b0;
            timer <= '0;
            state <= RELEASED;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
            neg   <= neg_next;
            pos   <= accept && !sample;
            if (sample == level || accept) cnt <= '0;
            else                           cnt <= cnt + CW'(1);
            if (accept) level <= sample;
            case (state)
                RELEASED: begin
                    timer <= '0;
                    if (accept && sample) state <= HOLD;
                end
                HOLD, REPEAT: begin
                    if (accept) begin
                        timer <= '0;
                        state <= RELEASED;
                    end else if (!repeat_en) begin
                        timer <= '0;
                    end else if (repeat_hit) begin
                        timer <= '0;
                        state <= REPEAT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    timer <= '0;
                    state <= RELEASED;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_debounce_array.sv
// Array of independent debounced keys with auto-repeat.
// o_any is registered alongside the per-channel press pulses.
module key_debounce_array #(
    parameter int N_CH          = 4,
    parameter int DEB_CYCLES    = 250000,
    parameter int ACTIVE_LOW    = 1,
    parameter int REPEAT_DELAY  = 12500000,
    parameter int REPEAT_PERIOD = 2500000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N_CH-1:0] i_in,
    input  logic [N_CH-1:0] i_repeat_en,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_neg,
    output logic [N_CH-1:0] o_pos,
    output logic            o_any
);

    logic [N_CH-1:0] neg_next;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        key_debounce_ch #(
            .DEB_CYCLES   (DEB_CYCLES),
            .ACTIVE_LOW   (ACTIVE_LOW),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clk      (i_clk),
            .rst      (i_rst),
            .in       (i_in[g]),
            .repeat_en(i_repeat_en[g]),
            .level    (o_level[g]),
            .neg      (o_neg[g]),
            .pos      (o_pos[g]),
            .neg_next (neg_next[g])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) o_any <= 1'b0;
        else       o_any <= |neg_next;
    end

endmodule

// File: tb/tb_key_debounce_array.sv
// Self-checking bench for key_debounce_array: vector table,
// directed repeat/bounce sequences and a random run against a model.
module tb_key_debounce_array;

    localparam int N   = 4;
    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] in;
    logic [N-1:0] en;
    logic [N-1:0] level;
    logic [N-1:0] neg;
    logic [N-1:0] pos;
    logic         any;

    int n_checks = 0;
    int n_errors = 0;

    key_debounce_array #(
        .N_CH         (N),
        .DEB_CYCLES   (DEB),
        .ACTIVE_LOW   (1),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_in       (in),
        .i_repeat_en(en),
        .o_level    (level),
        .o_neg      (neg),
        .o_pos      (pos),
        .o_any      (any)
    );

    always #5 clk = ~clk;

    // Reference model: pressed values seen through two edges of delay,
    // run length of disagreeing samples, and hold age for auto-repeat.
    logic [N-1:0] m_d1, m_d2;
    logic [N-1:0] m_lvl, m_neg, m_pos;
    logic         m_any;
    int           m_run[N];
    int           m_age[N];
    bit           m_first[N];

    task automatic model_step();
        logic d;
        logic was_held;
        logic rel;
        m_neg = '0;
        m_pos = '0;
        if (rst) begin
            m_d1  = '0;
            m_d2  = '0;
            m_lvl = '0;
            for (int c = 0; c < N; c++) begin
                m_run[c]   = 0;
                m_age[c]   = 0;
                m_first[c] = 1'b1;
            end
        end else begin
            for (int c = 0; c < N; c++) begin
                d        = m_d2[c];
                was_held = m_lvl[c];
                rel      = 1'b0;
                if (d != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DEB) begin
                        m_run[c] = 0;
                        m_lvl[c] = d;
                        if (d) begin
                            m_neg[c]   = 1'b1;
                            m_age[c]   = 0;
                            m_first[c] = 1'b1;
                        end else begin
                            m_pos[c] = 1'b1;
                            rel      = 1'b1;
                            m_age[c] = 0;
                        end
                    end
                end else begin
                    m_run[c] = 0;
                end
                if (was_held && !rel) begin
                    if (en[c]) begin
                        m_age[c]++;
                        if (m_age[c] == (m_first[c] ? RD : RP)) begin
                            m_neg[c]   = 1'b1;
                            m_age[c]   = 0;
                            m_first[c] = 1'b0;
                        end
                    end else begin
                        m_age[c] = 0;
                    end
                end
            end
            m_d2 = m_d1;
            m_d1 = ~in;
        end
        m_any = |m_neg;
    endtask

    task automatic check(input string name, input logic [12:0] act,
                         input logic [12:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h",
                     name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model", {level, neg, pos, any},
              {m_lvl, m_neg, m_pos, m_any});
    endtask

    typedef struct {
        logic [N-1:0] in;
        logic [N-1:0] en;
        logic         rst;
        int           edges;
        logic [N-1:0] lvl;
        logic [N-1:0] neg;
        logic [N-1:0] pos;
        logic         any;
    } vec_t;

    vec_t tbl[18];
    int   p_found;
    int   pulses[$];
    int   exp_pulses[7] = '{0, 10, 15, 20, 25, 30, 35};
    int   n_neg, n_pos, pos_at;

    initial begin
        tbl[0]  = '{4'hF, 4'h0, 1'b0, 2, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[1]  = '{4'hE, 4'h0, 1'b0, 5, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[2]  = '{4'hE, 4'h0, 1'b0, 1, 4'h1, 4'h1, 4'h0, 1'b1};
        tbl[3]  = '{4'hE, 4'h0, 1'b0, 1, 4'h1, 4'h0, 4'h0, 1'b0};
        tbl[4]  = '{4'hE, 4'h0, 1'b0, 50, 4'h1, 4'h0, 4'h0, 1'b0};
        tbl[5]  = '{4'hF, 4'h0, 1'b0, 5, 4'h1, 4'h0, 4'h0, 1'b0};
        tbl[6]  = '{4'hF, 4'h0, 1'b0, 1, 4'h0, 4'h0, 4'h1, 1'b0};
        tbl[7]  = '{4'hF, 4'h0, 1'b0, 1, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[8]  = '{4'h5, 4'h0, 1'b0, 5, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[9]  = '{4'h5, 4'h0, 1'b0, 1, 4'hA, 4'hA, 4'h0, 1'b1};
        tbl[10] = '{4'h5, 4'h0, 1'b0, 1, 4'hA, 4'h0, 4'h0, 1'b0};
        tbl[11] = '{4'hF, 4'h0, 1'b0, 6, 4'h0, 4'h0, 4'hA, 1'b0};
        tbl[12] = '{4'hF, 4'h0, 1'b0, 2, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[13] = '{4'hE, 4'h0, 1'b0, 8, 4'h1, 4'h0, 4'h0, 1'b0};
        tbl[14] = '{4'hE, 4'h0, 1'b1, 1, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[15] = '{4'hE, 4'h0, 1'b0, 5, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[16] = '{4'hE, 4'h0, 1'b0, 1, 4'h1, 4'h1, 4'h0, 1'b1};
        tbl[17] = '{4'hF, 4'h0, 1'b0, 10, 4'h0, 4'h0, 4'h0, 1'b0};

        rst = 1'b1;
        in  = 4'hF;
        en  = 4'h0;
        tick();
        tick();
        check("reset", {level, neg, pos, any}, 13'h0);

        for (int i = 0; i < 18; i++) begin
            rst = tbl[i].rst;
            in  = tbl[i].in;
            en  = tbl[i].en;
            for (int e = 0; e < tbl[i].edges; e++) tick();
            check($sformatf("vec%0d", i), {level, neg, pos, any},
                  {tbl[i].lvl, tbl[i].neg, tbl[i].pos, tbl[i].any});
        end
        rst = 1'b0;

        // bouncing key on channel 1 never gets accepted
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) in[1] = ~in[1];
            tick();
            check("bounce", {3'b0, level[1], neg[1], pos[1]}, 6'h0);
        end
        in = 4'hF;
        for (int i = 0; i < 8; i++) tick();

        // auto-repeat on channel 2
        en      = 4'b0100;
        in      = 4'b1011;
        p_found = 0;
        for (int i = 1; i <= 20 && p_found == 0; i++) begin
            tick();
            if (neg[2]) p_found = i;
        end
        check("press_edge", 13'(p_found), 13'd6);
        if (p_found != 0) begin
            pulses.push_back(0);
            for (int k = 1; k < 40; k++) begin
                tick();
                if (neg[2]) pulses.push_back(k);
            end
            check("repeat_cnt", 13'(pulses.size()), 13'd7);
            for (int k = 0; k < 7; k++) begin
                if (k < pulses.size())
                    check($sformatf("repeat%0d", k), 13'(pulses[k]),
                          13'(exp_pulses[k]));
            end
        end

        // release while repeating; timer expiry coincides with release
        in     = 4'hF;
        n_neg  = 0;
        n_pos  = 0;
        pos_at = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (neg[2]) n_neg++;
            if (pos[2]) begin
                n_pos++;
                pos_at = k;
                check("neg_in_pos", 13'(neg[2]), 13'd0);
            end
        end
        check("rel_pos_cnt", 13'(n_pos), 13'd1);
        check("rel_pos_at", 13'(pos_at), 13'd6);
        check("rel_neg_cnt", 13'(n_neg), 13'd1);
        en = 4'h0;

        // random run against the model
        for (int t = 0; t < 3000; t++) begin
            rst = ($urandom_range(0, 499) == 0);
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 7) == 0) in[c] = ~in[c];
                if ($urandom_range(0, 63) == 0) en[c] = ~en[c];
            end
            if ($urandom_range(0, 99) < 3) in = $urandom_range(0, 15);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
